// File: rtl/fetch_pkg.sv
// Shared defaults and the queue-entry layout for the instruction-fetch stage.
package fetch_pkg;
  localparam int          FETCH_ADDR_W   = 32;
  localparam int          FETCH_DATA_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0;
  localparam logic [31:0] FETCH_RESET_RA = 32'h0;

  // Entry layout at default widths; parameterised modules rebuild it locally.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } qentry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem handshake, decode handshake and branch-unit link.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
);
  logic              halt;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              br_valid;
  logic [ADDR_W-1:0] next_PC;
  logic [ADDR_W-1:0] next_RA;
  logic [ADDR_W-1:0] curr_PC;
  logic [ADDR_W-1:0] curr_RA;

  modport master (
    input  halt, imem_gnt, imem_rvalid, imem_rdata, instr_ready, br_valid, next_PC, next_RA,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, curr_PC, curr_RA
  );

  modport slave (
    output halt, imem_gnt, imem_rvalid, imem_rdata, instr_ready, br_valid, next_PC, next_RA,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, curr_PC, curr_RA
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO; the head entry is a register driving the outputs directly.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = FETCH_ADDR_W + FETCH_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic         vld,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;

  // flush pops the head and discards whatever sits behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign vld   = (cnt != 2'd0);
  assign head  = ent0;
  assign count = cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC/RA, runs one imem request at a time and
// redirects on branch-unit resolution.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter logic [ADDR_W-1:0] RESET_RA = ADDR_W'(FETCH_RESET_RA)
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] tag_pc;
  logic              outstanding;
  logic              squash;

  logic              req;
  logic              gnt_fire;
  logic              resp;
  logic              consume;
  logic              redirect;
  logic              push;
  logic [1:0]        qcount;
  logic              qvld;
  entry_t            qhead;
  entry_t            qdin;

  // Requests are capped by free queue slots, so the queue never overflows.
  assign req      = !rst && !bus.halt && !outstanding &&
                    (({1'b0, qcount} + {2'b00, outstanding}) < 3'd2);
  assign gnt_fire = req && bus.imem_gnt;
  assign resp     = bus.imem_rvalid && outstanding;
  assign consume  = qvld && bus.instr_ready;
  assign redirect = consume && bus.br_valid && (bus.next_PC != (qhead.pc + ONE));
  assign push     = resp && !squash && !redirect;
  assign qdin     = '{instr: bus.imem_rdata, pc: tag_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      ra          <= RESET_RA;
      tag_pc      <= '0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
    end else begin
      if (redirect)      fpc <= bus.next_PC;
      else if (gnt_fire) fpc <= fpc + ONE;

      if (gnt_fire) tag_pc <= fpc;

      if (gnt_fire)  outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      // A response landing in the redirect cycle is dropped directly; only a
      // request still in flight afterwards needs the squash marker.
      if (redirect && (gnt_fire || (outstanding && !resp))) squash <= 1'b1;
      else if (resp)                                         squash <= 1'b0;

      if (consume && bus.br_valid) ra <= bus.next_RA;
    end
  end

  fetch_queue #(.W(ADDR_W + DATA_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (qdin),
    .pop   (consume),
    .flush (redirect),
    .vld   (qvld),
    .head  (qhead),
    .count (qcount)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc;
  assign bus.instr_valid = qvld;
  assign bus.instr       = qhead.instr;
  assign bus.instr_pc    = qhead.pc;
  assign bus.curr_PC     = qhead.pc;
  assign bus.curr_RA     = ra;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem responder plus a program-order stream model.
module tb_fetch_unit;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h10;
  localparam logic [31:0] RRA = 32'h77;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC), .RESET_RA(RRA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // memory responder state
  bit          pend, stale;
  int          cnt, lat_min, lat_max, gnt_pct;
  logic [31:0] paddr;

  // reference: next instruction in program order and architectural RA
  logic [31:0] exp_pc, exp_ra;
  logic [31:0] got_pc[$];
  int          got_cyc[$];
  int          cyc, n_gnt, n_cons;

  bit          held, hold_req, br_prev;
  logic [31:0] held_pc, held_instr, hold_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle(input bit rdy, input bit brv, input logic [31:0] npc,
                       input logic [31:0] nra, input bit hlt);
    bit rv, g, fire, cons, taken;
    rv = 1'b0;
    bus.imem_rdata = $urandom;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        rv = 1'b1;
        pend = 1'b0;
        bus.imem_rdata = stale ? 32'hDEADBEEF : (paddr ^ 32'hA5A5);
        stale = 1'b0;
      end
    end
    g = !pend && ($urandom_range(99) < gnt_pct);
    bus.halt = hlt; bus.instr_ready = rdy; bus.br_valid = brv;
    bus.next_PC = npc; bus.next_RA = nra;
    bus.imem_gnt = g; bus.imem_rvalid = rv;
    #1;
    if (hlt) chk("halt_noreq", bus.imem_req, 0);
    if (pend && !stale) chk("one_outstanding", bus.imem_req, 0);
    if (hold_req && bus.imem_req && !br_prev) chk("addr_stable", bus.imem_addr, hold_addr);
    fire = bus.imem_req && g;
    cons = bus.instr_valid && rdy;
    taken = 1'b0;
    if (fire) begin
      pend = 1'b1; stale = 1'b0; paddr = bus.imem_addr;
      cnt = int'($urandom_range(lat_max, lat_min));
      n_gnt++;
    end
    if (cons) begin
      chk("pc", bus.instr_pc, exp_pc);
      chk("instr", bus.instr, exp_pc ^ 32'hA5A5);
      chk("curr_pc", bus.curr_PC, exp_pc);
      chk("curr_ra", bus.curr_RA, exp_ra);
      got_pc.push_back(bus.instr_pc);
      got_cyc.push_back(cyc);
      n_cons++;
      if (brv) begin
        taken = (npc != exp_pc + 32'd1);
        exp_ra = nra;
        exp_pc = npc;
      end else begin
        exp_pc = exp_pc + 32'd1;
      end
    end
    hold_req = bus.imem_req && !g; hold_addr = bus.imem_addr;
    br_prev = cons && brv;
    held = bus.instr_valid && !rdy; held_pc = bus.instr_pc; held_instr = bus.instr;
    @(negedge clk);
    cyc++;
    if (taken) chk("bubble", bus.instr_valid, 0);
    if (held) begin
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_pc", bus.instr_pc, held_pc);
      chk("hold_instr", bus.instr, held_instr);
    end
    if (cons && brv) chk("ra_update", bus.curr_RA, exp_ra);
  endtask

  task automatic do_reset(input bit keep);
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.instr_ready = 0;
    bus.br_valid = 0; bus.halt = 0;
    rst = 1'b1;
    #2;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, RPC);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_ra", bus.curr_RA, RRA);
    if (keep) stale = pend;
    else begin pend = 0; stale = 0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RPC; exp_ra = RRA;
    held = 0; hold_req = 0; br_prev = 0;
    got_pc.delete(); got_cyc.delete();
    cyc = 0; n_gnt = 0; n_cons = 0;
  endtask

  task automatic run_to_head(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.instr_valid && bus.instr_pc == pc) found = 1;
      else cycle(1, 0, 32'h0, 32'h0, 0);
    end
    chk("reach_head", found, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus.instr_valid) ok = 1;
      else cycle(0, 0, 32'h0, 32'h0, 0);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int hv[4];
    int lv[4];
    hv = '{0, 1, 1, 2};
    lv = '{1, 1, 2, 1};
    rst = 1; pend = 0; stale = 0;
    bus.halt = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.instr_ready = 0; bus.br_valid = 0; bus.next_PC = 0; bus.next_RA = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    @(negedge clk);

    // sequential fetch, memory always grants with 1-cycle latency
    do_reset(0);
    repeat (8) cycle(1, 0, 32'h0, 32'h0, 0);
    chk("seq_len", got_pc.size() >= 3, 1);
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      chk("seq_pc", got_pc[i], RPC + 32'(i));
      chk("seq_cyc", got_cyc[i], 2 + 2 * i);
    end

    // backpressure: only two fetches fit, head stays put
    do_reset(0);
    repeat (10) cycle(0, 0, 32'h0, 32'h0, 0);
    chk("bp_grants", n_gnt, 2);
    chk("bp_valid", bus.instr_valid, 1);
    chk("bp_head", bus.instr_pc, RPC);
    repeat (8) cycle(1, 0, 32'h0, 32'h0, 0);
    chk("bp_len", got_pc.size() >= 3, 1);
    for (int i = 0; i < 3 && i < got_pc.size(); i++) chk("bp_order", got_pc[i], RPC + 32'(i));

    // taken branch at 0x12 in several fetch phases (gnt same cycle, rvalid same
    // cycle, request in flight, queue full)
    for (int v = 0; v < 4; v++) begin
      lat_min = lv[v]; lat_max = lv[v];
      do_reset(0);
      run_to_head(32'h12);
      repeat (hv[v]) cycle(0, 0, 32'h0, 32'h0, 0);
      chk("tk_head", bus.instr_pc, 32'h12);
      cycle(1, 1, 32'h40, 32'h13, 0);
      chk("tk_ra", bus.curr_RA, 32'h13);
      wait_valid("tk_wait");
      chk("tk_next", bus.instr_pc, 32'h40);
      cycle(1, 0, 32'h0, 32'h0, 0);
      wait_valid("tk_wait2");
      chk("tk_next2", bus.instr_pc, 32'h41);
    end

    // not-taken branch with the successor already queued: no bubble
    lat_min = 1; lat_max = 1;
    do_reset(0);
    run_to_head(32'h12);
    repeat (3) cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(1, 1, 32'h13, 32'h99, 0);
    chk("nt_valid", bus.instr_valid, 1);
    chk("nt_pc", bus.instr_pc, 32'h13);
    chk("nt_ra", bus.curr_RA, 32'h99);
    // redirect to the top of the address space, then wrap to zero
    cycle(1, 1, 32'hFFFFFFFF, 32'h14, 0);
    wait_valid("wrap_wait");
    chk("wrap_top", bus.instr_pc, 32'hFFFFFFFF);
    cycle(1, 0, 32'h0, 32'h0, 0);
    wait_valid("wrap_wait2");
    chk("wrap_zero", bus.instr_pc, 32'h0);

    // reset while a request is in flight; its late response must be ignored
    lat_min = 3; lat_max = 3;
    do_reset(0);
    cycle(1, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 32'h0, 32'h0, 0);
    do_reset(1);
    lat_min = 1; lat_max = 1;
    repeat (10) cycle(1, 0, 32'h0, 32'h0, 0);
    chk("rst_restart_len", got_pc.size() >= 2, 1);
    if (got_pc.size() > 0) chk("rst_restart_pc", got_pc[0], RPC);

    // randomized traffic
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      bit rdy, brv, hlt;
      logic [31:0] npc;
      rdy = ($urandom_range(9) < 7);
      brv = ($urandom_range(4) == 0);
      hlt = ($urandom_range(9) == 0);
      if ($urandom_range(1) == 0) npc = exp_pc + 32'd1;
      else if ($urandom_range(7) == 0) npc = 32'hFFFFFFFF;
      else npc = $urandom;
      cycle(rdy, brv, npc, $urandom, hlt);
    end
    chk("rand_progress", n_cons >= 300, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
